hdu_multicycle: RTL
===================

# hdu_multicycle

Parametrised load-use hazard detection unit for the segmented core, successor to the single-cycle load-use detector. Tracks loads from Execute through a configurable number of post-Execute cycles, compares their destination against up to `NUM_SRC` Decode source registers, and emits stall, bubble and flush controls. It sits beside the Decode/Execute pipeline registers and drives their enable/clear inputs. It ignores register x0, honours per-source "used" flags, and gives taken-branch flush priority over stall.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `NUM_SRC`, 2: Decode source operands checked; legal range 1..3.
- `LOAD_LAT`, 1: cycles after Execute before load data is forwardable; legal range 1..4.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `DMRd_ex` input 1: Execute instruction is a load.
- `rd_ex` input `REG_ADDR_W`: Execute destination register.
- `rs_de` input `NUM_SRC*REG_ADDR_W`: Decode sources, packed; source i occupies bits [i*W +: W].
- `rs_used_de` input `NUM_SRC`: bit i set means source i is read by the Decode instruction.
- `BrTaken_ex` input 1: branch or jump resolved taken in Execute.
- `HDUStall` output 1: hold PC and the Fetch/Decode register.
- `BubbleEX` output 1: load a NOP into the Decode/Execute register.
- `FlushDE` output 1: clear the Fetch/Decode register (wrong-path instruction).

## Operation
- **Tracker.** `LOAD_LAT-1` entries, ages 1..`LOAD_LAT-1`, each holding {valid, rd}.
  - Every cycle, entry k moves to k+1 and the oldest entry drops out.
  - Entry 1 loads {`DMRd_ex && rd_ex!=0`, `rd_ex`}.
  - The tracker never stalls: stages after Execute always advance.
  - With `LOAD_LAT=1` the tracker is empty and only the live Execute load is compared.
- **Match.** Source i matches when all of the following hold:
  - `rs_used_de[i]=1`
  - `rs_de[i]!=0`
  - it equals either `rd_ex` with `DMRd_ex=1`, or the rd of any valid tracker entry.
- **HDUStall / BubbleEX.** `HDUStall = BubbleEX = (any source matches) && !BrTaken_ex`.
- **FlushDE.** `FlushDE = BrTaken_ex`.
- **Branch in Execute.** A branch in Execute cannot be a load, so its own entry-1 push is invalid. Tracker entries from older loads stay valid.
- **Outputs.** All three outputs are combinational from inputs and tracker state. They are forced to 0 while `rst=1`.

## Timing
- **Reset.** On any clock edge with `rst=1`, all tracker valids clear. Outputs read 0 during reset and in the first cycle after reset, unless a live Execute match exists.
- **Stall length.** A load in Execute at cycle t with a dependent instruction in Decode gives `HDUStall=1` for cycles t..t+`LOAD_LAT`-1, exactly `LOAD_LAT` cycles. The dependent instruction enters Execute at t+`LOAD_LAT`+1.
- **Combinational path.** Zero-latency from inputs to outputs. Tracker update takes effect one clock later.
- **Back-to-back loads.** With different rd, the stall is governed by the youngest matching entry. A match on the same rd in two entries still counts as a single stall condition.
- **Stall and branch together.** `FlushDE=1` and `HDUStall=0`.
- **Reset mid-stall.** The stall ends immediately and pending entries are discarded.

## Configuration
- **`HDU_PERF_CNT_EN` defined:**
  - 32-bit output `stall_cnt`: increments on every cycle with `HDUStall=1`.
  - 32-bit output `loaduse_cnt`: increments on each rising edge of `HDUStall`.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- **Not defined:** neither port nor its registers exist. Behaviour is otherwise identical.

## Structure
- **Package `hdu_pkg`:**
  - `REG_ADDR_W` default constant.
  - `regaddr_t` typedef.
  - `ld_pend_t` struct {valid, rd}.
  - Function `src_hit(regaddr_t rs, logic used, regaddr_t rd, logic v)`.
- **Sub-module `hdu_load_tracker`:** the parametrised age shift register, generated empty when `LOAD_LAT=1`.
- **Top level:** per-source compare generate loop, OR-reduction and output gating.

## Test plan
1. **Reset.** `rst=1` for 3 cycles with `DMRd_ex=1`, `rd_ex=5`, `rs_de[0]=5`, `used=1` -> all outputs 0. On release, the live match gives `HDUStall=1`.
2. **Basic load-use.** `LOAD_LAT=1`: load x7 in Execute, Decode reads x7 -> one stall cycle. Same stimulus with `LOAD_LAT=3` -> `HDUStall` and `BubbleEX` high for exactly 3 cycles.
3. **Filtering.**
   - Load x0 with Decode reading x0 -> no stall.
   - Load x9 with `rs_de[1]=9` but `rs_used_de[1]=0` -> no stall.
4. **Branch priority.** `LOAD_LAT=2`: a tracked load of x4 is at age 1 while `BrTaken_ex=1` and Decode reads x4 -> `FlushDE=1`, `HDUStall=0`. In the next cycle, the tracker has aged out and there is no stall.
5. **Back-to-back loads.** `LOAD_LAT=3`, `NUM_SRC=3`: load x3, then load x8, then an instruction with sources {8,3,0} -> the stall persists until the x8 entry ages out. Check the total stall count.
6. **Performance counters.** With `HDU_PERF_CNT_EN`: two separate 2-cycle stalls -> `stall_cnt=4`, `loaduse_cnt=2`. Preload `stall_cnt` to 0xFFFF_FFFF by force -> it holds that value.

Source files
------------

// File: rtl/hdu_pkg.sv
// Shared types and helpers for the multicycle load-use hazard unit.
// Provides the register address type, pending-load record and compare helper.
package hdu_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] regaddr_t;

   typedef struct packed {
      logic     valid;
      regaddr_t rd;
   } ld_pend_t;

   // A read source hits a pending load when it is used, is not x0 and
   // names the load's destination.
   function automatic logic src_hit(regaddr_t rs, logic used,
                                    regaddr_t rd, logic v);
      return used && v && (rs != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/hdu_load_tracker.sv
// Age shift register of loads that left Execute but whose data is not
// yet forwardable. Ports: clk, rst, i_push_v/i_push_rd (entry-1 load),
// o_vld/o_rd (packed entries, index 0 = age 1). Empty when LOAD_LAT=1.
module hdu_load_tracker #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   localparam int NE        = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push_v,
   input  logic [REG_ADDR_W-1:0]    i_push_rd,
   output logic [NE-1:0]            o_vld,
   output logic [NE*REG_ADDR_W-1:0] o_rd
);

   if (LOAD_LAT > 1) begin : g_trk
      logic [NE-1:0]            r_vld;
      logic [NE*REG_ADDR_W-1:0] r_rd;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= i_push_v;
            for (int k = 1; k < NE; k++) begin
               r_vld[k] <= r_vld[k-1];
            end
         end
      end

      // Addresses need no reset: they are only observed under valid.
      always_ff @(posedge clk) begin
         r_rd[REG_ADDR_W-1:0] <= i_push_rd;
         for (int k = 1; k < NE; k++) begin
            r_rd[k*REG_ADDR_W +: REG_ADDR_W] <=
               r_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W];
         end
      end

      assign o_vld = r_vld;
      assign o_rd  = r_rd;
   end else begin : g_none
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, i_push_v, i_push_rd};
      assign o_vld    = '0;
      assign o_rd     = '0;
   end

endmodule

// File: rtl/hdu_multicycle.sv
// Load-use hazard detection with multicycle load latency; drives stall,
// bubble and flush. Ports: clk, rst, DMRd_ex, rd_ex, rs_de, rs_used_de,
// BrTaken_ex -> HDUStall, BubbleEX, FlushDE. Macro HDU_PERF_CNT_EN adds
// stall_cnt and loaduse_cnt counters.
module hdu_multicycle
   import hdu_pkg::*;
#(
   parameter int REG_ADDR_W = hdu_pkg::REG_ADDR_W,
   parameter int NUM_SRC    = 2,
   parameter int LOAD_LAT   = 1,
   localparam int NE        = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          DMRd_ex,
   input  logic [REG_ADDR_W-1:0]         rd_ex,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_de,
   input  logic [NUM_SRC-1:0]            rs_used_de,
   input  logic                          BrTaken_ex,
   output logic                          HDUStall,
   output logic                          BubbleEX,
   output logic                          FlushDE
`ifdef HDU_PERF_CNT_EN
   ,
   output logic [31:0]                   stall_cnt,
   output logic [31:0]                   loaduse_cnt
`endif
);

   logic                     w_push_v;
   logic [NE-1:0]            w_vld;
   logic [NE*REG_ADDR_W-1:0] w_rd;
   logic [NUM_SRC-1:0]       w_hit;
   logic                     w_stall;

   assign w_push_v = DMRd_ex && (rd_ex != '0);

   hdu_load_tracker #(
      .REG_ADDR_W (REG_ADDR_W),
      .LOAD_LAT   (LOAD_LAT)
   ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .i_push_v  (w_push_v),
      .i_push_rd (rd_ex),
      .o_vld     (w_vld),
      .o_rd      (w_rd)
   );

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR_W-1:0] w_rs;
      logic                  w_h;
      logic                  w_u;

      assign w_rs = rs_de[i*REG_ADDR_W +: REG_ADDR_W];
      assign w_u  = rs_used_de[i];

      if (REG_ADDR_W == $bits(regaddr_t)) begin : g_pkg
         always_comb begin
            w_h = src_hit(regaddr_t'(w_rs), w_u, regaddr_t'(rd_ex), DMRd_ex);
            for (int k = 0; k < NE; k++) begin
               w_h |= src_hit(regaddr_t'(w_rs), w_u,
                              regaddr_t'(w_rd[k*REG_ADDR_W +: REG_ADDR_W]),
                              w_vld[k]);
            end
         end
      end else begin : g_gen
         always_comb begin
            w_h = DMRd_ex && (w_rs == rd_ex);
            for (int k = 0; k < NE; k++) begin
               if (w_vld[k] && (w_rs == w_rd[k*REG_ADDR_W +: REG_ADDR_W]))
                  w_h = 1'b1;
            end
            w_h = w_h && w_u && (w_rs != '0);
         end
      end

      assign w_hit[i] = w_h;
   end

   // A taken branch squashes Decode, so a stall there would be pointless.
   assign w_stall  = !rst && (|w_hit) && !BrTaken_ex;
   assign HDUStall = w_stall;
   assign BubbleEX = w_stall;
   assign FlushDE  = !rst && BrTaken_ex;

`ifdef HDU_PERF_CNT_EN
   logic        r_stall_d;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_lu_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_d   <= 1'b0;
         r_stall_cnt <= '0;
         r_lu_cnt    <= '0;
      end else begin
         r_stall_d <= w_stall;
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_stall && !r_stall_d && (r_lu_cnt != '1))
            r_lu_cnt <= r_lu_cnt + 32'd1;
      end
   end

   assign stall_cnt   = r_stall_cnt;
   assign loaduse_cnt = r_lu_cnt;
`endif

endmodule
